aes_key_expand: RTL
===================

Name: aes_key_expand

Overview:
- On-the-fly AES-128 key schedule that produces round keys 0..10 in order, one per handshake.
- Sits directly upstream of the MixColumns/AddRoundKey XOR network and drives its 128-bit round_key input.
- Uses the same byte ordering as the round datapath: byte k occupies bits [127-8k : 120-8k], and word w0 is bits [127:96].
- Completes one key per cycle under continuous ready, so a full schedule takes 11 accepted transfers.

Parameters:
- NUM_ROUNDS, 10, index of the last round key. Only 10 (AES-128) is supported; any other value is a compile-time error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a schedule; sampled only in IDLE.
- key_in  input  128  cipher key; sampled on the cycle start is accepted.
- key_ready  input  1  consumer accepts round_key when key_valid && key_ready.
- key_valid  output  1  round_key/round_idx are valid.
- round_key  output  128  current round key.
- round_idx  output  4  index 0..10 of round_key.
- busy  output  1  high from start acceptance until the final handshake.
- done  output  1  one-cycle pulse in the cycle after round key 10 is accepted.

Behaviour:
- Reset, asynchronous:
  - key_valid, busy and done are 0.
  - round_key and round_idx are 0.
  - The rcon register is 0x01.
  - The FSM is in IDLE.
  - Reset asserted mid-schedule aborts the schedule immediately, with no done pulse.
- FSM states: IDLE and EMIT.
- IDLE:
  - On start=1, at the next edge: round_key<=key_in, round_idx<=0, rcon<=0x01, key_valid<=1, busy<=1, go to EMIT.
  - Latency is 1 cycle from start to key 0 valid.
- EMIT:
  - key_valid stays 1, and round_key/round_idx hold stable, until a handshake.
  - Handshake with round_idx<10:
    - round_key<=next(round_key, rcon), round_idx<=round_idx+1, rcon<=xtime(rcon).
    - key_valid remains 1, so the next key is presented in the following cycle.
  - Handshake with round_idx==10: key_valid<=0, busy<=0, done<=1 for one cycle, return to IDLE.
- next():
  - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - RotWord moves the most significant byte to the least significant position.
  - SubWord applies the FIPS-197 S-box to each of the 4 bytes. There are 4 parallel lookups, implemented as a local combinational 256-entry function.
- rcon sequence by round: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits.
- Ignored starts:
  - start during EMIT is ignored; key_in is not resampled.
  - start in the same cycle as the final handshake is ignored. A new start is accepted one cycle later, in IDLE, including the cycle in which done=1.
- key_ready is allowed to be low indefinitely. No output changes while stalled.
- All outputs are registered; there is no combinational path from key_ready to any output.

Test Plan:
- Nominal schedule:
  - Stimulus: rst, key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse, key_ready=1 continuously.
  - Required response: idx0=key_in one cycle after start, idx1=a0fafe1788542cb123a339392a6c7605, idx2=f2c295f27a96b9435935807a7359f67f, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - The 11 consecutive valid cycles are followed by done=1 and busy=0.
- All-zero key:
  - Required response: idx1=62636363626363636263636362636363, idx10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - Stimulus: random key_ready toggling on the nominal key.
  - Required response: each key is held stable while key_ready=0, the same 11 values appear in order, and done pulses exactly once.
- Ignored start:
  - Stimulus: a second start with a different key_in at idx3.
  - Required response: the sequence is unchanged.
  - A start in the cycle done=1 is accepted, and key 0 of the new key appears on the next cycle.
- Reset mid-operation:
  - Stimulus: rst asserted asynchronously at idx5.
  - Required response: key_valid, busy and round_idx are 0 immediately and no done pulse occurs.
  - A new start after reset release yields the nominal idx1 value.

Source files
------------

// File: rtl/aes_key_expand.sv
// On-the-fly AES-128 key schedule: emits round keys 0..10 in order, one per valid/ready handshake.
// Key 0 appears one cycle after start; a stalled key_ready simply holds the current key and index.
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_key_expand supports only NUM_ROUNDS = 10 (AES-128)");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, temp;
    logic [31:0] n0, n1, n2, n3;
    logic [127:0] next_key;

    always_comb begin
        w0       = round_key[127:96];
        w1       = round_key[95:64];
        w2       = round_key[63:32];
        w3       = round_key[31:0];
        temp     = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
        n0       = w0 ^ temp;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            round_key <= '0;
            round_idx <= '0;
            rcon      <= 8'h01;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        round_idx <= '0;
                        rcon      <= 8'h01;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (key_valid && key_ready) begin
                        if (round_idx == LAST_IDX) begin
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            round_key <= next_key;
                            round_idx <= round_idx + 4'd1;
                            rcon      <= xtime(rcon);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
